// File: rtl/psum_drain_pkg.sv
// rtl/psum_drain_pkg.sv - shared state encoding and derived-size helpers for psum_drain
package psum_drain_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SEND = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Number of GBF beats needed to carry the whole flat psum vector.
  function automatic int calc_num_beats(input int total_bits, input int word_bits);
    return total_bits / word_bits;
  endfunction

  // Beat counter width; a single-beat tile still needs a 1-bit counter.
  function automatic int calc_cnt_width(input int num_beats);
    return (num_beats > 1) ? $clog2(num_beats) : 1;
  endfunction

endpackage

// File: rtl/relu_lane.sv
// rtl/relu_lane.sv - per-element ReLU clamp, combinational
module relu_lane #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] in,
  input  logic             en,
  output logic [WIDTH-1:0] out
);

  // Negative values (MSB set) are forced to zero when the clamp is enabled.
  assign out = (en && in[WIDTH-1]) ? '0 : in;

endmodule

// File: rtl/psum_drain.sv
// rtl/psum_drain.sv - snapshots the PE psum vector and streams it to the GBF in beats
module psum_drain
  import psum_drain_pkg::*;
#(
  parameter int ROW               = 16,
  parameter int COL               = 16,
  parameter int OUT_BITWIDTH      = 16,
  parameter int GBF_DATA_BITWIDTH = 512,
  parameter int GBF_ADDR_BITWIDTH = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [OUT_BITWIDTH*ROW*COL-1:0]     psum_in,
  input  logic                                relu_en,
  input  logic [GBF_ADDR_BITWIDTH-1:0]        base_addr,
  output logic                                gbf_w_en,
  input  logic                                gbf_ready,
  output logic [GBF_ADDR_BITWIDTH-1:0]        gbf_w_addr,
  output logic [GBF_DATA_BITWIDTH-1:0]        gbf_w_data,
  output logic                                busy,
  output logic                                done
);

  localparam int TOTAL_BITS = OUT_BITWIDTH * ROW * COL;
  localparam int LANES      = ROW * COL;
  localparam int NUM_BEATS  = calc_num_beats(TOTAL_BITS, GBF_DATA_BITWIDTH);
  localparam int CNT_W      = calc_cnt_width(NUM_BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

  state_t                                      state;
  logic [TOTAL_BITS-1:0]                       relu_vec;
  logic [NUM_BEATS-1:0][GBF_DATA_BITWIDTH-1:0] snap;
  logic [CNT_W-1:0]                            beat_cnt;
  logic [GBF_ADDR_BITWIDTH-1:0]                base_q;

  // ReLU sits in front of the snapshot so the register holds final write data.
  for (genvar i = 0; i < LANES; i++) begin : g_relu
    relu_lane #(
      .WIDTH(OUT_BITWIDTH)
    ) u_relu_lane (
      .in (psum_in[i*OUT_BITWIDTH +: OUT_BITWIDTH]),
      .en (relu_en),
      .out(relu_vec[i*OUT_BITWIDTH +: OUT_BITWIDTH])
    );
  end

  // Tile FSM: capture on start, advance one beat per accepted write, pulse done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      snap     <= '0;
      beat_cnt <= '0;
      base_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            snap     <= relu_vec;
            base_q   <= base_addr;
            beat_cnt <= '0;
            state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (gbf_ready) begin
            if (beat_cnt == LAST_BEAT) begin
              state <= ST_DONE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs decode only registered state, so gbf_ready never reaches them combinationally.
  // Address and data read as zero outside SEND to keep the bus quiet between tiles.
  assign gbf_w_en   = (state == ST_SEND);
  assign gbf_w_addr = gbf_w_en ? (base_q + GBF_ADDR_BITWIDTH'(beat_cnt)) : '0;
  assign gbf_w_data = gbf_w_en ? snap[beat_cnt] : '0;
  assign busy       = (state == ST_SEND) || (state == ST_DONE);
  assign done       = (state == ST_DONE);

endmodule

// File: doc/psum_drain.md
# psum_drain

Downstream drain stage for the PE array.
- On `start`, snapshots the full flat psum vector (`OUT_BITWIDTH*ROW*COL` bits) and optionally applies ReLU per element.
- Streams the snapshot to the global buffer as `GBF_DATA_BITWIDTH`-wide beats over a valid/ready write handshake, at consecutive addresses.
- Frees the PE array to start the next tile as soon as the snapshot is taken.

## Interface
Parameters:
- `ROW`, 16, PE array rows
- `COL`, 16, PE array columns
- `OUT_BITWIDTH`, 16, psum element width (signed two's complement)
- `GBF_DATA_BITWIDTH`, 512, GBF write word width
  - `OUT_BITWIDTH*ROW*COL` must be an integer multiple of it.
  - `GBF_DATA_BITWIDTH` must be a multiple of `OUT_BITWIDTH`.
- `GBF_ADDR_BITWIDTH`, 8, GBF address width

Ports:
- `clk`  in  1  clock; one clock domain.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  single-cycle request; captures `psum_in`, `relu_en` and `base_addr`.
- `psum_in`  in  `OUT_BITWIDTH*ROW*COL`  flat psum vector from the PE array.
- `relu_en`  in  1  clamp negative elements to 0.
- `base_addr`  in  `GBF_ADDR_BITWIDTH`  GBF address of beat 0.
- `gbf_w_en`  out  1  write valid.
- `gbf_ready`  in  1  GBF accepts the current beat.
- `gbf_w_addr`  out  `GBF_ADDR_BITWIDTH`  write address.
- `gbf_w_data`  out  `GBF_DATA_BITWIDTH`  write data.
- `busy`  out  1  high in SEND and DONE.
- `done`  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- Derived constant: `NUM_BEATS = OUT_BITWIDTH*ROW*COL / GBF_DATA_BITWIDTH`.
- States: IDLE, SEND, DONE.
- IDLE:
  - `start=1` loads the snapshot register (ReLU already applied if `relu_en`).
  - Latches `base_addr`, clears the beat counter, moves to SEND.
- SEND:
  - `gbf_w_en=1`.
  - `gbf_w_data` = snapshot bits `[GBF_DATA_BITWIDTH*(k+1)-1 : GBF_DATA_BITWIDTH*k]`, where k is the beat counter.
  - `gbf_w_addr = base + k`, modulo `2^GBF_ADDR_BITWIDTH` (wraps silently).
  - On `gbf_ready`: k increments. If `k == NUM_BEATS-1`, move to DONE instead.
- DONE: `done=1` for one cycle, then IDLE.
- ReLU: an element whose MSB is 1 becomes 0; all others pass unchanged. Element order and bit positions are preserved.
- `start` while `busy`: ignored. The snapshot and counter are untouched.
- `psum_in` changes after the capture cycle: no effect on the beats in flight.

## Timing
- Reset values: state IDLE, `gbf_w_en=0`, `gbf_w_addr=0`, `gbf_w_data=0`, `busy=0`, `done=0`, beat counter 0.
- All outputs are registered or decoded from registered state only. There is no combinational path from `gbf_ready` to any output.
- `start` at cycle t: beat 0 is valid at t+1.
- With `gbf_ready` held high: beats occupy t+1 … t+NUM_BEATS, `done` is at t+NUM_BEATS+1, and IDLE is reached at t+NUM_BEATS+2.
- The earliest accepted next `start` is at t+NUM_BEATS+2.
- Handshake:
  - Once `gbf_w_en` rises, data and address stay stable until a cycle where `gbf_w_en & gbf_ready` holds.
  - `gbf_w_en` never drops mid-tile.
- A backpressure cycle (`gbf_ready=0`) adds exactly one cycle of latency per stalled cycle.
- `reset` mid-transfer: the next cycle is IDLE with the reset values. The tile is dropped and `done` is not asserted.
- `reset` and `start` in the same cycle: reset wins.

## Structure
- Shared package/header holds:
  - state encoding (IDLE=0, SEND=1, DONE=2)
  - `NUM_BEATS` and beat-counter width `$clog2(NUM_BEATS)` (minimum 1) as derived localparams
- Sub-module `relu_lane`: parameterized by `WIDTH`, with inputs `in` and `en` and output `out`; purely combinational. Instantiated `ROW*COL` times in a generate loop in front of the snapshot register.
- The top level holds the FSM, the snapshot register, the beat counter, and the beat-select mux.

## Test plan
Configuration: `ROW=2`, `COL=2`, `OUT_BITWIDTH=16`, `GBF_DATA_BITWIDTH=32`, `GBF_ADDR_BITWIDTH=4`, giving `NUM_BEATS=2`.
- Basic drain: `psum_in=64'h0004_0003_0002_0001`, `relu_en=0`, `base_addr=5`, `gbf_ready=1` → beat (addr 5, `32'h0002_0001`) at t+1, beat (addr 6, `32'h0004_0003`) at t+2, `done` at t+3.
- ReLU: `psum_in=64'h8000_7FFF_FFFF_0010`, `relu_en=1` → beats `32'h0000_0010` then `32'h0000_7FFF`.
- Backpressure: `gbf_ready` low at t+1 and t+2 → beat 0 is held stable through t+3, beat 1 goes out at t+4, `done` at t+5.
- Address wrap: `base_addr=15` → beats go to addresses 15 then 0.
- Snapshot and ignore: change `psum_in` and pulse `start` at t+1 → the original data is still sent, and exactly one `done` is produced.
- Reset mid-op: assert `reset` at t+1 → `gbf_w_en=0` and `busy=0` at t+2, no `done`; a following `start` drains normally.
